// File: rtl/cpu_pkg.sv
// Shared CPU encodings: writeback destination/data selects and fixed register numbers.
// Used by writeback_regfile and reg_file (REGFILE_BYPASS_EN is consumed in reg_file).
package cpu_pkg;

    localparam int          NUM_REGS  = 32;
    localparam int          REG_W     = 5;
    localparam int          DATA_W    = 32;
    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [4:0]  REG_RA    = 5'd31;
    localparam logic [4:0]  REG_K0    = 5'd26;

    typedef enum logic [1:0] {
        DST_RT = 2'b00,
        DST_RD = 2'b01,
        DST_RA = 2'b10,
        DST_K0 = 2'b11
    } reg_dst_e;

    typedef enum logic [1:0] {
        WB_ALU     = 2'b00,
        WB_MEM     = 2'b01,
        WB_LINK    = 2'b10,
        WB_ALU_ALT = 2'b11
    } mem_to_reg_e;

endpackage

// File: rtl/reg_file.sv
// 32x32 register file, two combinational read ports, $0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward a same-cycle write onto the read ports.
module reg_file
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [REG_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_W-1:0]  raddr1_i,
    input  logic [REG_W-1:0]  raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != REG_ZERO)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Bypass is held off during reset so reads always see the cleared array then.
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        rdata2_o = regs_q[raddr2_i];
`ifdef REGFILE_BYPASS_EN
        if (reset && we_i && (waddr_i != REG_ZERO)) begin
            if (raddr1_i == waddr_i) rdata1_o = wdata_i;
            if (raddr2_i == waddr_i) rdata2_o = wdata_i;
        end
`endif
        if (raddr1_i == REG_ZERO) rdata1_o = '0;
        if (raddr2_i == REG_ZERO) rdata2_o = '0;
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: destination/data muxes, committed-write counter and the register file.
// REGFILE_BYPASS_EN (see reg_file) enables same-cycle write-to-read forwarding.
module writeback_regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] PC_plus4,
    input  logic [DATA_W-1:0] Data_Mem_Out,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [1:0]        RegDst,
    input  logic              RegWr,
    input  logic [1:0]        MemToReg,
    input  logic [REG_W-1:0]  RegisterRd,
    input  logic [REG_W-1:0]  RegisterRt,
    input  logic [REG_W-1:0]  Read_register1,
    input  logic [REG_W-1:0]  Read_register2,
    output logic [DATA_W-1:0] Read_data1,
    output logic [DATA_W-1:0] Read_data2,
    output logic [REG_W-1:0]  Write_register,
    output logic [DATA_W-1:0] Write_data,
    output logic              Write_en,
    output logic [DATA_W-1:0] Wb_count
);

    logic [DATA_W-1:0] wbCount_q;
    logic [DATA_W-1:0] wbCount_d;

    always_comb begin
        Write_register = RegisterRt;
        case (RegDst)
            DST_RT:  Write_register = RegisterRt;
            DST_RD:  Write_register = RegisterRd;
            DST_RA:  Write_register = REG_RA;
            DST_K0:  Write_register = REG_K0;
            default: Write_register = RegisterRt;
        endcase
    end

    always_comb begin
        Write_data = ALUOut;
        case (MemToReg)
            WB_ALU:     Write_data = ALUOut;
            WB_MEM:     Write_data = Data_Mem_Out;
            WB_LINK:    Write_data = PC_plus4;
            WB_ALU_ALT: Write_data = ALUOut;
            default:    Write_data = ALUOut;
        endcase
    end

    assign Write_en = RegWr && (Write_register != REG_ZERO);

    // Counts only writes that actually land in the array; wraps naturally at 2^32.
    always_comb begin
        wbCount_d = wbCount_q;
        if (Write_en) wbCount_d = wbCount_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wbCount_q <= '0;
        else        wbCount_q <= wbCount_d;
    end

    assign Wb_count = wbCount_q;

    reg_file u_reg_file (
        .clk      (clk),
        .reset    (reset),
        .we_i     (Write_en),
        .waddr_i  (Write_register),
        .wdata_i  (Write_data),
        .raddr1_i (Read_register1),
        .raddr2_i (Read_register2),
        .rdata1_o (Read_data1),
        .rdata2_o (Read_data2)
    );

endmodule
